// File: rtl/xoodoo_round_ctrl_sca_pkg.sv
// Shared types and constants for the DOM Xoodoo round sequencer.
// FSM encoding, j selector geometry, latency counter width and the j start value.
package xoodoo_ctrl_pkg;

    localparam int unsigned J_W        = 13;
    localparam int unsigned J_LAST_BIT = 11;
    localparam int unsigned CNT_W      = 3;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRdi,
        StPipe,
        StDone
    } ctrl_state_e;

    // Start position so the last round always lands on j[J_LAST_BIT].
    function automatic logic [J_W-1:0] j_init(input int unsigned num_rounds);
        return J_W'(1) << ((J_LAST_BIT + 1) - num_rounds);
    endfunction

endpackage

// File: rtl/xoodoo_round_ctrl_sca_if.sv
// Control bundle between the round sequencer and its wrapper/round datapath.
// slave: the sequencer side; master: the side issuing start and supplying rdi_valid.
interface xoodoo_round_ctrl_sca_if;

    logic                              start;
    logic                              rdi_valid;
    logic                              rdi_ready;
    logic                              rdi_en;
    logic                              state_sel;
    logic                              state_we;
    logic [xoodoo_ctrl_pkg::J_W-1:0]   j_out;
    logic                              busy;
    logic                              done;

    modport slave (
        input  start,
        input  rdi_valid,
        output rdi_ready,
        output rdi_en,
        output state_sel,
        output state_we,
        output j_out,
        output busy,
        output done
    );

    modport master (
        output start,
        output rdi_valid,
        input  rdi_ready,
        input  rdi_en,
        input  state_sel,
        input  state_we,
        input  j_out,
        input  busy,
        input  done
    );

endinterface

// File: rtl/xoodoo_round_ctrl_sca.sv
// Round sequencer for the two-share DOM Xoodoo round: load, rdi handshake, pipeline wait, done.
// Macro XOODOO_RDI_STALL_EN enables stalling on rdi_valid; otherwise RDI lasts one cycle.
module xoodoo_round_ctrl_sca
    import xoodoo_ctrl_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS    = 12,
    parameter int unsigned ROUND_LATENCY = 2
) (
    input logic                     clk,
    input logic                     rst,
    xoodoo_round_ctrl_sca_if.slave  bus
);

    localparam logic [J_W-1:0]   J_INIT    = j_init(NUM_ROUNDS);
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(ROUND_LATENCY - 1);

    ctrl_state_e      state_q, state_d;
    logic [J_W-1:0]   j_q, j_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rdi_hs;

`ifdef XOODOO_RDI_STALL_EN
    assign rdi_hs = bus.rdi_valid;
`else
    logic unused_rdi_valid;
    assign unused_rdi_valid = bus.rdi_valid;
    assign rdi_hs           = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            j_q     <= J_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) state_d = StLoad;
            end
            StLoad: state_d = StRdi;
            StRdi: begin
                if (rdi_hs) begin
                    cnt_d   = CNT_START;
                    state_d = StPipe;
                end
            end
            StPipe: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    j_d     = j_q << 1;
                    state_d = j_q[J_LAST_BIT] ? StDone : StRdi;
                end
            end
            StDone: begin
                j_d     = J_INIT;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.rdi_ready = 1'b0;
        bus.rdi_en    = 1'b0;
        bus.state_sel = 1'b0;
        bus.state_we  = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        unique case (state_q)
            StIdle: ;
            StLoad: begin
                bus.busy     = 1'b1;
                bus.state_we = 1'b1;
            end
            StRdi: begin
                bus.busy      = 1'b1;
                bus.rdi_ready = rdi_hs;
                bus.rdi_en    = rdi_hs;
            end
            StPipe: begin
                bus.busy = 1'b1;
                if (cnt_q == '0) begin
                    bus.state_sel = 1'b1;
                    bus.state_we  = 1'b1;
                end
            end
            StDone: bus.done = 1'b1;
            default: ;
        endcase
    end

    assign bus.j_out = j_q;

endmodule

// File: tb/tb_xoodoo_round_ctrl_sca.sv
// Scoreboard bench for xoodoo_round_ctrl_sca: expected write/done events are queued at start.
// Covers reset, full runs at 12 and 6 rounds, rdi stalls, mid-run reset and ignored starts.
module tb_xoodoo_round_ctrl_sca;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic sel;
    logic rdi_valid;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int cyc;
        bit is_done;
        bit fb;
    } ev_t;

    always #5 clk = ~clk;

    xoodoo_round_ctrl_sca_if bus12 ();
    xoodoo_round_ctrl_sca_if bus6 ();

    assign bus12.start     = start & ~sel;
    assign bus6.start      = start & sel;
    assign bus12.rdi_valid = rdi_valid;
    assign bus6.rdi_valid  = rdi_valid;

    xoodoo_round_ctrl_sca #(.NUM_ROUNDS(12), .ROUND_LATENCY(2)) dut12 (
        .clk (clk),
        .rst (rst),
        .bus (bus12)
    );

    xoodoo_round_ctrl_sca #(.NUM_ROUNDS(6), .ROUND_LATENCY(2)) dut6 (
        .clk (clk),
        .rst (rst),
        .bus (bus6)
    );

    logic [12:0] o_j;
    logic o_busy, o_done, o_we, o_sel, o_en, o_rdy;

    always_comb begin
        o_j    = sel ? bus6.j_out     : bus12.j_out;
        o_busy = sel ? bus6.busy      : bus12.busy;
        o_done = sel ? bus6.done      : bus12.done;
        o_we   = sel ? bus6.state_we  : bus12.state_we;
        o_sel  = sel ? bus6.state_sel : bus12.state_sel;
        o_en   = sel ? bus6.rdi_en    : bus12.rdi_en;
        o_rdy  = sel ? bus6.rdi_ready : bus12.rdi_ready;
    end

    task automatic check_idle(input string name, input logic [12:0] jexp);
        checks++;
        if (o_j !== jexp || o_busy !== 1'b0 || o_done !== 1'b0 || o_we !== 1'b0 ||
            o_en !== 1'b0) begin
            errors++;
            $display("FAIL %s: j=%h busy=%b done=%b we=%b en=%b, required j=%h and all 0",
                     name, o_j, o_busy, o_done, o_we, o_en, jexp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;  // start together with rst must lose
        sel = 1'b0;
        rdi_valid = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check_idle("reset_n12", 13'h0001);
        sel = 1'b1;
        #1;
        check_idle("reset_n6", 13'h0040);
        sel = 1'b0;
    endtask

    // One permutation on the selected instance; stall_len cycles of rdi_valid=0
    // from the first RDI cycle of stall_round (only honoured with stalling built in).
    task automatic run_perm(input string name, input bit use6, input int n,
                            input int stall_round, input int stall_len, input bit extra_starts);
        ev_t q[$];
        ev_t ev;
        logic [12:0] jinit, jm;
        int cyc, pulses, eff, sh;
        sel = use6;
        jinit = 13'd1 << (12 - n);
`ifdef XOODOO_RDI_STALL_EN
        eff = stall_len;
`else
        eff = 0;
`endif
        q.push_back('{cyc: 1, is_done: 1'b0, fb: 1'b0});
        for (int k = 1; k <= n; k++) begin
            sh = (stall_len > 0 && k >= stall_round) ? eff : 0;
            q.push_back('{cyc: 1 + 3 * k + sh, is_done: 1'b0, fb: 1'b1});
        end
        sh = (stall_len > 0 && stall_round <= n) ? eff : 0;
        q.push_back('{cyc: 2 + 3 * n + sh, is_done: 1'b1, fb: 1'b0});
        jm = jinit;
        pulses = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (q.size() > 0 && cyc < 200) begin
            rdi_valid = !(stall_len > 0 && cyc >= 3 * stall_round - 1 &&
                          cyc < 3 * stall_round - 1 + stall_len);
            start = extra_starts && (cyc == 3 || cyc == 20);
            #1;
            checks++;
            if (o_j !== jm) begin
                errors++;
                $display("FAIL %s j_out cyc %0d: got %h want %h", name, cyc, o_j, jm);
            end
            checks++;
            if (o_rdy !== o_en) begin
                errors++;
                $display("FAIL %s rdi_ready cyc %0d: got %b want %b", name, cyc, o_rdy, o_en);
            end
            if (o_en === 1'b1) pulses++;
            if (q[0].cyc == cyc) begin
                ev = q.pop_front();
                checks++;
                if (ev.is_done) begin
                    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_we !== 1'b0) begin
                        errors++;
                        $display("FAIL %s done cyc %0d: done=%b busy=%b we=%b want 1/0/0",
                                 name, cyc, o_done, o_busy, o_we);
                    end
                    jm = jinit;
                end else begin
                    if (o_we !== 1'b1 || o_sel !== ev.fb || o_busy !== 1'b1) begin
                        errors++;
                        $display("FAIL %s write cyc %0d: we=%b sel=%b busy=%b want 1/%b/1",
                                 name, cyc, o_we, o_sel, o_busy, ev.fb);
                    end
                    if (ev.fb) jm = jm << 1;
                end
            end else begin
                checks++;
                if (o_we !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s quiet cyc %0d: we=%b done=%b busy=%b want 0/0/1",
                             name, cyc, o_we, o_done, o_busy);
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        rdi_valid = 1'b1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s timeout: %0d events pending, next due cyc %0d",
                     name, q.size(), q[0].cyc);
        end
        checks++;
        if (pulses != n) begin
            errors++;
            $display("FAIL %s rdi_en pulses: got %0d want %0d", name, pulses, n);
        end
        #1;
        check_idle({name, "_after"}, jinit);
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);  // now cycle 15: round 5 PIPE
        #1;
        checks++;
        if (o_busy !== 1'b1 || o_j !== 13'h0010) begin
            errors++;
            $display("FAIL reset_mid pre: busy=%b j=%h want 1/0010", o_busy, o_j);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle("reset_mid_post", 13'h0001);
        run_perm("after_reset", 1'b0, 12, 0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        run_perm("basic_n12", 1'b0, 12, 0, 0, 1'b0);
        run_perm("stall_r3", 1'b0, 12, 3, 4, 1'b0);
        run_perm("basic_n6", 1'b1, 6, 0, 0, 1'b0);
        run_perm("stall_n6_r1", 1'b1, 6, 1, 2, 1'b0);
        test_reset_mid();
        run_perm("ignored_starts", 1'b0, 12, 0, 0, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        check_idle("final_idle", 13'h0001);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
